// File: rtl/mc_control_unit_v2.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder driving datapath selects and enables.
// Ports: clk/reset (async active-low), zero, OP, Funct, mem_ready in; mux selects, write enables,
//        ALUControl, p_state and illegal_op out. Only the state register is sequential.
module mc_control_unit_v2 #(
  parameter bit EN_IMM   = 1'b1,
  parameter bit EN_BNE   = 1'b1,
  parameter bit EN_JUMP  = 1'b1,
  parameter bit MEM_WAIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       zero,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       MemWrite,
  output logic       ImmExt,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic [3:0] p_state,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_IMMEX   = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd15;

  logic [3:0] state;
  logic [3:0] next_state;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       branch;
  logic       branch_ne;
  logic       rdy;

  // Opcode decode; disabled features simply never match and fall through to ILLEGAL.
  logic is_lw, is_sw, is_rtype, funct_ok, is_beq, is_bne, is_addi, is_andi, is_ori, is_j;

  assign is_lw    = (OP == 6'b100011);
  assign is_sw    = (OP == 6'b101011);
  assign is_rtype = (OP == 6'b000000);
  assign is_beq   = (OP == 6'b000100);
  assign is_bne   = EN_BNE  && (OP == 6'b000101);
  assign is_addi  = EN_IMM  && (OP == 6'b001000);
  assign is_andi  = EN_IMM  && (OP == 6'b001100);
  assign is_ori   = EN_IMM  && (OP == 6'b001101);
  assign is_j     = EN_JUMP && (OP == 6'b000010);
  assign funct_ok = (Funct == 6'b100000) || (Funct == 6'b100010) || (Funct == 6'b100100) ||
                    (Funct == 6'b100101) || (Funct == 6'b101010);

  // Without the wait handshake the memory is assumed single-cycle.
  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  assign p_state = state;

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:   next_state = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw)                    next_state = S_MEMADR;
        else if (is_rtype && funct_ok)         next_state = S_EXECUTE;
        else if (is_beq || is_bne)             next_state = S_BRANCH;
        else if (is_addi || is_andi || is_ori) next_state = S_IMMEX;
        else if (is_j)                         next_state = S_JUMP;
        else                                   next_state = S_ILLEGAL;
      end
      S_MEMADR:  next_state = is_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   next_state = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:   next_state = S_FETCH;
      S_MEMWR:   next_state = rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: next_state = S_ALUWB;
      S_ALUWB:   next_state = S_FETCH;
      S_BRANCH:  next_state = S_FETCH;
      S_IMMEX:   next_state = S_IMMWB;
      S_IMMWB:   next_state = S_FETCH;
      S_JUMP:    next_state = S_FETCH;
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    MemWrite   = 1'b0;
    ImmExt     = 1'b0;
    PCSrc      = 2'b00;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = rdy;
        pc_write = rdy;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      // The write strobe stays up for the whole wait so the memory can sample it late.
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        alu_op    = 2'b01;
        PCSrc     = 2'b01;
        branch    = is_beq;
        branch_ne = is_bne;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (!is_addi) begin
          alu_op = 2'b11;
          ImmExt = 1'b1;
        end
      end
      S_IMMWB:   RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign PCEn = pc_write | (branch & zero) | (branch_ne & ~zero);

  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b110;
      2'b11: ALUControl = is_ori ? 3'b001 : 3'b000;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit_v2.sv
// Bench for mc_control_unit_v2: two instances (single-cycle memory with all features, and
// wait-handshake memory with optional opcodes disabled) exercised one at a time against
// per-instruction state paths and a per-state output table.
module tb_mc_control_unit_v2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, zero, mem_ready;
  logic [5:0] op, funct;

  logic       a_irw, a_iord, a_rdst, a_m2r, a_rw, a_srca, a_mw, a_immext, a_pcen, a_ill;
  logic [1:0] a_srcb, a_pcsrc;
  logic [2:0] a_alu;
  logic [3:0] a_ps;
  logic       b_irw, b_iord, b_rdst, b_m2r, b_rw, b_srca, b_mw, b_immext, b_pcen, b_ill;
  logic [1:0] b_srcb, b_pcsrc;
  logic [2:0] b_alu;
  logic [3:0] b_ps;

  mc_control_unit_v2 #(.EN_IMM(1'b1), .EN_BNE(1'b1), .EN_JUMP(1'b1), .MEM_WAIT(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .zero(zero), .OP(op), .Funct(funct), .mem_ready(mem_ready),
    .IRWrite(a_irw), .IorD(a_iord), .RegDst(a_rdst), .MemtoReg(a_m2r), .RegWrite(a_rw),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .MemWrite(a_mw), .ImmExt(a_immext), .PCSrc(a_pcsrc),
    .PCEn(a_pcen), .ALUControl(a_alu), .p_state(a_ps), .illegal_op(a_ill));

  mc_control_unit_v2 #(.EN_IMM(1'b0), .EN_BNE(1'b0), .EN_JUMP(1'b0), .MEM_WAIT(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .zero(zero), .OP(op), .Funct(funct), .mem_ready(mem_ready),
    .IRWrite(b_irw), .IorD(b_iord), .RegDst(b_rdst), .MemtoReg(b_m2r), .RegWrite(b_rw),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .MemWrite(b_mw), .ImmExt(b_immext), .PCSrc(b_pcsrc),
    .PCEn(b_pcen), .ALUControl(b_alu), .p_state(b_ps), .illegal_op(b_ill));

  // {IRWrite,IorD,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,MemWrite,ImmExt,PCSrc,PCEn,ALUControl,illegal_op}
  logic [16:0] obs_a, obs_b;
  assign obs_a = {a_irw, a_iord, a_rdst, a_m2r, a_rw, a_srca, a_srcb, a_mw, a_immext, a_pcsrc, a_pcen, a_alu, a_ill};
  assign obs_b = {b_irw, b_iord, b_rdst, b_m2r, b_rw, b_srca, b_srcb, b_mw, b_immext, b_pcsrc, b_pcen, b_alu, b_ill};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

  int checks = 0;
  int errors = 0;
  int path[$];

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    if (f == F_SUB) return 3'b110;
    if (f == F_AND) return 3'b000;
    if (f == F_OR)  return 3'b001;
    if (f == F_SLT) return 3'b111;
    return 3'b010;
  endfunction

  function automatic bit funct_legal(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

  // Output table per state, straight from the datapath control description.
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] o, input logic z, input logic rdy,
                                          input logic [5:0] f);
    logic irw, iord, rdst, m2r, rw, srca, mw, immext, pcen, ill;
    logic [1:0] srcb, pcsrc;
    logic [2:0] alu;
    {irw, iord, rdst, m2r, rw, srca, mw, immext, pcen, ill} = '0;
    srcb = 2'b00; pcsrc = 2'b00; alu = 3'b010;
    case (st)
      0:  begin irw = rdy; pcen = rdy; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin srca = 1'b1; srcb = 2'b10; end
      3:  iord = 1'b1;
      4:  begin m2r = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin srca = 1'b1; alu = funct_alu(f); end
      7:  begin rdst = 1'b1; rw = 1'b1; end
      8:  begin srca = 1'b1; pcsrc = 2'b01; alu = 3'b110; pcen = (o == BEQ) ? z : ~z; end
      9:  begin
            srca = 1'b1; srcb = 2'b10;
            if (o != ADDI) begin immext = 1'b1; alu = (o == ORI) ? 3'b001 : 3'b000; end
          end
      10: rw = 1'b1;
      11: begin pcsrc = 2'b10; pcen = 1'b1; end
      15: ill = 1'b1;
      default: ;
    endcase
    return {irw, iord, rdst, m2r, rw, srca, srcb, mw, immext, pcsrc, pcen, alu, ill};
  endfunction

  // Whole-instruction state sequence (without wait repeats) for a given configuration.
  task automatic build_path(input int sel, input logic [5:0] o, input logic [5:0] f);
    bit full = (sel == 0);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    if (o == LW)                                          begin path.push_back(2); path.push_back(3); path.push_back(4); end
    else if (o == SW)                                     begin path.push_back(2); path.push_back(5); end
    else if (o == RT && funct_legal(f))                   begin path.push_back(6); path.push_back(7); end
    else if (o == BEQ || (full && o == BNE))              path.push_back(8);
    else if (full && (o == ADDI || o == ANDI || o == ORI)) begin path.push_back(9); path.push_back(10); end
    else if (full && o == JMP)                            path.push_back(11);
    else                                                  path.push_back(15);
  endtask

  function automatic logic [16:0] sel_obs(input int sel);
    return (sel == 0) ? obs_a : obs_b;
  endfunction

  function automatic logic [3:0] sel_ps(input int sel);
    return (sel == 0) ? a_ps : b_ps;
  endfunction

  // Entered and left at a falling edge. An illegal instruction is held then cleared by reset.
  task automatic run_instr(input int sel, input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int waitn);
    int idx = 0;
    int waited = 0;
    int guard = 0;
    int st;
    logic rdy;
    op = o; funct = f;
    build_path(sel, o, f);
    while (idx < path.size()) begin
      st = path[idx];
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : (zmode != 0);
      mem_ready = (waitn < 0) ? 1'($urandom_range(0, 1)) : (waited >= waitn);
      #1;
      rdy = (sel == 0) ? 1'b1 : mem_ready;
      chk($sformatf("i%0d_op%0h_st%0d_pstate", sel, o, st), 17'(sel_ps(sel)), 17'(st));
      chk($sformatf("i%0d_op%0h_st%0d_outs", sel, o, st), sel_obs(sel), exp_out(st, o, zero, rdy, f));
      @(posedge clk);
      if ((st == 0 || st == 3 || st == 5) && !rdy) waited++;
      else begin idx++; waited = 0; end
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        errors++;
        $error("FAIL i%0d_op%0h_timeout observed=%0d expected=%0d", sel, o, guard, path.size());
        break;
      end
    end
    if (path[path.size()-1] == 15) begin
      repeat (3) begin
        zero = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("i%0d_ill_hold_pstate", sel), 17'(sel_ps(sel)), 17'd15);
        chk($sformatf("i%0d_ill_hold_outs", sel), sel_obs(sel), exp_out(15, o, zero, 1'b0, f));
        @(posedge clk);
        @(negedge clk);
      end
      #2;
      if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
      #1;
      rdy = (sel == 0) ? 1'b1 : mem_ready;
      chk($sformatf("i%0d_ill_reset_pstate", sel), 17'(sel_ps(sel)), 17'd0);
      chk($sformatf("i%0d_ill_reset_outs", sel), sel_obs(sel), exp_out(0, o, zero, rdy, f));
      @(negedge clk);
      if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    end
  endtask

  task automatic rand_instr(output logic [5:0] o, output logic [5:0] f);
    case ($urandom_range(0, 9))
      0: o = LW;   1: o = SW;   2: o = RT;   3: o = BEQ;  4: o = BNE;
      5: o = ADDI; 6: o = ANDI; 7: o = ORI;  8: o = JMP;
      default: o = 6'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: f = F_ADD; 1: f = F_SUB; 2: f = F_AND; 3: f = F_OR; 4: f = F_SLT;
      default: f = 6'($urandom);
    endcase
  endtask

  initial begin
    logic [5:0] ro, rf;
    rst_a = 1'b0; rst_b = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = LW; funct = F_ADD;
    @(negedge clk);
    #1;
    chk("reset_a_pstate", 17'(a_ps), 17'd0);
    chk("reset_a_outs", obs_a, exp_out(0, op, zero, 1'b1, funct));
    chk("reset_b_pstate", 17'(b_ps), 17'd0);
    chk("reset_b_outs_notready", obs_b, exp_out(0, op, zero, 1'b0, funct));
    mem_ready = 1'b1;
    #1;
    chk("reset_b_outs_ready", obs_b, exp_out(0, op, zero, 1'b1, funct));
    @(negedge clk);

    // Single-cycle memory, all opcodes enabled.
    rst_a = 1'b1;
    run_instr(0, LW,   F_ADD, 0, 0);
    run_instr(0, RT,   F_OR,  0, 0);
    run_instr(0, BEQ,  F_ADD, 1, 0);
    run_instr(0, BNE,  F_ADD, 1, 0);
    run_instr(0, BEQ,  F_ADD, 0, 0);
    run_instr(0, BNE,  F_ADD, 0, 0);
    run_instr(0, ORI,  F_ADD, 0, 0);
    run_instr(0, ANDI, F_ADD, 0, 0);
    run_instr(0, ADDI, F_ADD, 0, 0);
    run_instr(0, SW,   F_ADD, 0, 0);
    run_instr(0, JMP,  F_ADD, 0, 0);
    run_instr(0, RT,   F_SLT, 0, 0);
    run_instr(0, 6'b111111, F_ADD, 0, 0);
    run_instr(0, RT,   6'b000111, 0, 0);
    repeat (40) begin
      rand_instr(ro, rf);
      run_instr(0, ro, rf, -1, -1);
    end

    // Wait-handshake memory, optional opcodes disabled.
    rst_a = 1'b0;
    rst_b = 1'b1;
    run_instr(1, LW,   F_ADD, 0, 3);
    run_instr(1, SW,   F_ADD, 0, 3);
    run_instr(1, BEQ,  F_ADD, 1, 0);
    run_instr(1, ADDI, F_ADD, 0, 1);
    run_instr(1, BNE,  F_ADD, 0, 0);
    run_instr(1, JMP,  F_ADD, 0, 2);
    repeat (40) begin
      rand_instr(ro, rf);
      run_instr(1, ro, rf, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit_v2.md
Name: mc_control_unit_v2

Overview:
Next-generation multicycle MIPS control unit: a Moore FSM plus ALU decoder that drives the datapath's mux selects, write enables and ALU function.
Adds several features over the current controller:
- immediate ops (ADDI/ANDI/ORI), BNE and J;
- an optional memory wait handshake;
- an illegal-instruction trap.
Sits between the instruction register (OP, Funct) and the shared-memory multicycle datapath.

Parameters:
EN_IMM, 1, 1 = decode ADDI (001000), ANDI (001100), ORI (001101); 0 = these trap as illegal
EN_BNE, 1, 1 = decode BNE (000101); 0 = traps
EN_JUMP, 1, 1 = decode J (000010); 0 = traps
MEM_WAIT, 0, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored, treated as 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
zero  in  1  ALU zero flag
OP  in  6  instruction opcode
Funct  in  6  R-type function field
mem_ready  in  1  memory access complete (used only when MEM_WAIT=1)
IRWrite  out  1  instruction register load
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = memory data to register file
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
MemWrite  out  1  memory write
ImmExt  out  1  0 = sign-extend immediate, 1 = zero-extend immediate
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC load enable
ALUControl  out  3  ALU function
p_state  out  4  current state encoding
illegal_op  out  1  trap flag

Behaviour:
- State register:
  - Only sequential element.
  - reset low forces FETCH immediately, regardless of clk.
  - Mid-instruction reset abandons the instruction; no partial writes after deassertion.
- State encodings (p_state):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7
  - BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, ILLEGAL=15
  - 12-14 unused; if ever reached, next state is FETCH.
- Output generation:
  - All outputs are combinational from state; mem_ready gating and zero are the only Mealy terms.
  - Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH:
    - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00.
    - IRWrite and PCWrite assert only while rdy (rdy = mem_ready | ~MEM_WAIT).
    - Next state: DECODE if rdy, else FETCH.
  - DECODE:
    - Outputs: ALUSrcA=0, ALUSrcB=11, ALUop=00.
    - Next state by opcode:
      - LW (100011) or SW (101011) -> MEMADR
      - R-type (000000) with supported Funct -> EXECUTE
      - BEQ (000100), or BNE if enabled -> BRANCH
      - enabled immediate op -> IMMEX
      - J, if enabled -> JUMP
      - anything else, including unsupported Funct -> ILLEGAL
  - MEMADR:
    - Outputs: ALUSrcA=1, ALUSrcB=10, ALUop=00.
    - Next state: LW -> MEMRD; SW -> MEMWR.
  - MEMRD:
    - Outputs: IorD=1.
    - Next state: MEMWB if rdy, else hold.
  - MEMWB:
    - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
    - Next state: FETCH.
  - MEMWR:
    - Outputs: IorD=1, MemWrite=1, held for every wait cycle.
    - Next state: FETCH if rdy, else hold.
  - EXECUTE:
    - Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=10.
    - Next state: ALUWB.
  - ALUWB:
    - Outputs: RegDst=1, RegWrite=1.
    - Next state: FETCH.
  - BRANCH:
    - Outputs: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01.
    - Branch=1 for BEQ; BranchNe=1 for BNE.
    - Next state: FETCH.
  - IMMEX:
    - Outputs: ALUSrcA=1, ALUSrcB=10.
    - ALUop=00 for ADDI; ALUop=11 with ImmExt=1 for ANDI/ORI.
    - Next state: IMMWB.
  - IMMWB:
    - Outputs: RegDst=0, MemtoReg=0, RegWrite=1.
    - Next state: FETCH.
  - JUMP:
    - Outputs: PCSrc=10, PCWrite=1.
    - Next state: FETCH.
  - ILLEGAL:
    - Outputs: illegal_op=1.
    - Self-loop; exits only on reset. No write enables and no PCEn asserted.
- PCEn = PCWrite | (Branch & zero) | (BranchNe & ~zero).
- ALUControl:
  - ALUop 00 -> 010 (add)
  - ALUop 01 -> 110 (sub)
  - ALUop 11 -> 000 for ANDI, 001 for ORI
  - ALUop 10 decodes Funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
- Outputs at reset (FETCH): p_state=0, illegal_op=0, ALUSrcB=01, ALUControl=010, all other write enables 0. IRWrite=PCEn=1 when MEM_WAIT=0, =mem_ready when MEM_WAIT=1.
- Latency:
  - No waits: LW 5 cycles; SW, R-type, ADDI/ANDI/ORI 4; BEQ/BNE/J 3.
  - Each wait cycle adds 1.

Test Plan:
- LW (OP=100011), MEM_WAIT=0 -> p_state 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- R-type OR (Funct=100101) -> ALUControl=001 in EXECUTE; RegDst=1, RegWrite=1 in ALUWB; 4 cycles total.
- BEQ with zero=1 and BNE with zero=1 -> PCEn=1 for BEQ, PCEn=0 for BNE in BRANCH; repeat with zero=0 -> inverse.
- MEM_WAIT=1, mem_ready low 3 cycles during FETCH and during MEMWR -> state holds; IRWrite=0 and MemWrite=1 throughout; advance on the cycle mem_ready=1.
- OP=111111, and EN_IMM=0 with ADDI -> ILLEGAL (15), illegal_op=1 held with no writes; reset low mid-hold -> p_state=0 immediately.
- ORI (001101) -> ImmExt=1, ALUControl=001 in IMMEX; RegDst=0, RegWrite=1 in IMMWB.
